sobel_gradient: RTL
===================

Name: sobel_gradient

Overview:
- Streaming Canny stage directly downstream of SmoothingFilter.
- Consumes the smoothed pixel stream in raster order and holds two line buffers to form a 3x3 window.
- Computes Sobel Gx/Gy, an L1 gradient magnitude and a 2-bit quantised direction, and feeds the non-maximum-suppression stage.
- Emits interior pixels only: (IMG_W-2)*(IMG_H-2) outputs per frame.

Parameters:
- IMG_W, 64, pixels per line (>=3).
- IMG_H, 64, lines per frame (>=3).
- PIX_W, 8, smoothed pixel width (unsigned).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enb  in  1  clock enable; low = whole block frozen.
- pix_in  in  PIX_W  smoothed pixel.
- pix_valid  in  1  pix_in valid this cycle.
- pix_sof  in  1  qualifies pix_valid; marks pixel (0,0) of a frame.
- grad_mag  out  PIX_W+3  |Gx|+|Gy|.
- grad_dir  out  2  0=0deg, 1=45deg, 2=90deg, 3=135deg.
- out_valid  out  1  grad_* valid this cycle.
- out_sof  out  1  first interior output of a frame.
- out_eof  out  1  last interior output of a frame.

Behaviour:
- Reset (reset=0, async):
  - All outputs go to 0.
  - Row/col counters go to 0.
  - Line buffers and window are not cleared; their contents are don't-care until refilled.
  - After reset, input is ignored until the first pix_sof.
- Accept condition: enb & pix_valid (and, after reset, seen-sof).
- enb=0:
  - No state changes.
  - Outputs hold their values, including out_valid; downstream must also qualify with enb.
- Counters: col advances 0..IMG_W-1; on wrap, row advances 0..IMG_H-1, then wraps to 0.
- pix_sof with an accepted pixel forces that pixel to (0,0), even mid-frame; the partial frame is discarded.
- Window: p[r][c] for r,c in 0..2, with r=0 as the oldest line and c=0 as the oldest column.
  - Line buffers are IMG_W-deep shift/RAM structures.
- Output rule: an accepted pixel at (row>=2, col>=2) produces one output for centre (row-1, col-1).
  - out_valid pulses exactly 2 enabled cycles after the accepting cycle.
  - Stage 1: window update and Gx/Gy.
  - Stage 2: magnitude/direction register.
  - All other accepted pixels produce nothing.
- Window rows never straddle lines: pixels with col<2 are never centres, so no cross-line window is emitted.
- Arithmetic (signed, PIX_W+3 bits):
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
  - |Gx|,|Gy| <= 4*(2^PIX_W - 1).
  - grad_mag = |Gx| + |Gy|, exact with no saturation (max 2040 at PIX_W=8 fits 11 bits).
- Direction (ax=|Gx|, ay=|Gy|), evaluated in this order:
  - 5*ay <= 2*ax -> 0.
  - 5*ax <= 2*ay -> 2.
  - Otherwise sign(Gx)==sign(Gy) -> 1, else 3; zero counts as positive.
  - ax=ay=0 -> 0.
- Frame markers:
  - out_sof=1 with the output for centre (1,1).
  - out_eof=1 with the output for centre (IMG_H-2, IMG_W-2).
  - Both are only ever high together with out_valid.
- Reset mid-operation: the pipeline is cleared and no stale output is emitted; a new pix_sof is required.
- pix_valid gaps (enb=1): counters and window hold; no outputs appear except those already in flight.

Test Plan:
- Constant frame of 128, IMG_W=IMG_H=8 -> 36 outputs, all mag=0, dir=0; out_sof on 1st output, out_eof on 36th.
- Vertical step (cols 0-3 = 0, cols 4-7 = 255) -> centres at cols 3,4: Gx=1020, mag=1020, dir=0; other interior cols mag=0.
- Horizontal step (rows 0-3 = 0, rows 4-7 = 200) -> centres at rows 3,4: Gy=800, mag=800, dir=2.
- Diagonal ramp (pixel = 10*(r+c)) -> Gx=Gy=80, mag=160, dir=1; anti-diagonal (10*(r-c)+100) -> dir=3.
- enb low for 5 cycles mid-line, plus random pix_valid gaps -> output sequence and values identical to the gap-free run; outputs hold while enb=0.
- reset asserted at pixel (4,5), then pix_sof re-issued -> out_valid stays 0 until the new frame's (2,2) is accepted +2 cycles; the full 36-output frame follows.

Source files
------------

// File: rtl/sobel_gradient.sv
// Sobel stage: 3x3 window over the smoothed raster stream -> L1 gradient magnitude + 2-bit direction.
// Latency: 2 enabled cycles from accepting a window's bottom-right pixel to out_valid.
// Backpressure: none; enb=0 freezes every register, pix_valid gaps hold counters and window.
module sobel_gradient #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic [PIX_W+2:0] grad_mag,
  output logic [1:0]       grad_dir,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;
  localparam int DW = GW + 3;

  typedef logic [PIX_W-1:0]     pix_t;
  typedef logic signed [GW-1:0] grad_t;
  typedef struct packed {
    logic  vld;
    logic  sof;
    logic  eof;
    grad_t gx;
    grad_t gy;
  } s1_t;

  logic          seen_sof;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pix_t          lb0 [IMG_W];
  pix_t          lb1 [IMG_W];
  pix_t          win [3][3];
  pix_t          win_nxt [3][3];
  s1_t           s1;

  logic          accept;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          centre_ok;
  grad_t         gx_nxt;
  grad_t         gy_nxt;
  logic [GW-1:0] ax;
  logic [GW-1:0] ay;
  logic [DW-1:0] ax_w;
  logic [DW-1:0] ay_w;
  logic [GW-1:0] mag_nxt;
  logic [1:0]    dir_nxt;

  function automatic grad_t ext(input pix_t p);
    return grad_t'({3'b000, p});
  endfunction

  // A sof pixel is placed at (0,0) regardless of where the counters were.
  assign accept    = enb & pix_valid & (seen_sof | pix_sof);
  assign cur_col   = pix_sof ? '0 : col;
  assign cur_row   = pix_sof ? '0 : row;
  assign centre_ok = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win[r][1];
      win_nxt[r][1] = win[r][2];
    end
    win_nxt[0][2] = lb0[IMG_W-1];
    win_nxt[1][2] = lb1[IMG_W-1];
    win_nxt[2][2] = pix_in;

    gx_nxt = (ext(win_nxt[0][2]) + ext(win_nxt[1][2]) + ext(win_nxt[1][2]) + ext(win_nxt[2][2]))
           - (ext(win_nxt[0][0]) + ext(win_nxt[1][0]) + ext(win_nxt[1][0]) + ext(win_nxt[2][0]));
    gy_nxt = (ext(win_nxt[2][0]) + ext(win_nxt[2][1]) + ext(win_nxt[2][1]) + ext(win_nxt[2][2]))
           - (ext(win_nxt[0][0]) + ext(win_nxt[0][1]) + ext(win_nxt[0][1]) + ext(win_nxt[0][2]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_sof <= 1'b0;
      col      <= '0;
      row      <= '0;
      s1       <= '0;
    end else if (enb) begin
      if (accept) begin
        seen_sof <= 1'b1;
        if (cur_col == CW'(IMG_W-1)) begin
          col <= '0;
          row <= (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
      s1.vld <= accept & centre_ok;
      s1.sof <= accept & (cur_row == RW'(2)) & (cur_col == CW'(2));
      s1.eof <= accept & (cur_row == RW'(IMG_H-1)) & (cur_col == CW'(IMG_W-1));
      s1.gx  <= gx_nxt;
      s1.gy  <= gy_nxt;
    end
  end

  // Line buffers and window carry no reset; rows < 2 of a new frame refill them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[0] <= pix_in;
      lb0[0] <= lb1[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb1[i] <= lb1[i-1];
        lb0[i] <= lb0[i-1];
      end
      win <= win_nxt;
    end
  end

  always_comb begin
    ax      = s1.gx[GW-1] ? GW'(-s1.gx) : GW'(s1.gx);
    ay      = s1.gy[GW-1] ? GW'(-s1.gy) : GW'(s1.gy);
    ax_w    = DW'(ax);
    ay_w    = DW'(ay);
    mag_nxt = ax + ay;
    // tan(22.5deg) ~ 2/5: near-horizontal gradients first, then near-vertical, then the diagonals.
    if (((ay_w << 2) + ay_w) <= (ax_w << 1))
      dir_nxt = 2'd0;
    else if (((ax_w << 2) + ax_w) <= (ay_w << 1))
      dir_nxt = 2'd2;
    else if (s1.gx[GW-1] == s1.gy[GW-1])
      dir_nxt = 2'd1;
    else
      dir_nxt = 2'd3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grad_mag  <= '0;
      grad_dir  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (enb) begin
      out_valid <= s1.vld;
      out_sof   <= s1.sof;
      out_eof   <= s1.eof;
      if (s1.vld) begin
        grad_mag <= mag_nxt;
        grad_dir <= dir_nxt;
      end
    end
  end

endmodule
